clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; the successor to the fixed divide-by-8 divider.
- Generates out_clk = clk / N for any N in 2..2^WIDTH-1, plus a one-cycle tick at each period start.
- Odd N can optionally be produced with exact 50% duty.
- Divisor changes and stop/start requests take effect only at period boundaries, so no runt pulses. Used as the shared baud/strobe source for downstream serial and timer blocks.

Parameters:
- WIDTH, 8, width of the divisor and internal counter.
- DEFAULT_DIV, 8, divisor loaded at reset; must be in 2..2^WIDTH-1.
- ODD50, 0, when 1, odd divisors give an exact 50% duty using one falling-edge flop on clk.

Ports:
- clk  in  1  sole clock; all logic on rising edge except the ODD50 falling-edge flop.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run request; level sensitive.
- div_load  in  1  one-cycle strobe to request a new divisor.
- div_in  in  WIDTH  new divisor, sampled when div_load=1.
- div_pending  out  1  accepted divisor is waiting for the next boundary.
- div_err  out  1  one-cycle pulse: div_load rejected because div_in < 2.
- cur_div  out  WIDTH  divisor currently in effect.
- running  out  1  high while in RUN or STOPPING.
- tick  out  1  one-cycle pulse on the first clk cycle of every out_clk period.
- out_clk  out  1  divided clock.

Behaviour:
- Reset (reset=0, async):
  - cnt=0, cur_div=DEFAULT_DIV, pend_div=0, div_pending=0, div_err=0, tick=0, out_clk=0, running=0.
  - State=IDLE; the falling-edge flop is also cleared.
- Reset mid-period: outputs drop to reset values immediately; any pending divisor is lost.
- State machine:
  - IDLE: out_clk=0, cnt=0. If en=1 at a rising edge, go to RUN with cnt=0.
  - RUN: cnt counts 0..cur_div-1, then wraps to 0. On the wrap edge, if en=0 go to IDLE instead of wrapping.
  - en falling mid-period puts the block in STOPPING. STOPPING completes the current period, then goes to IDLE.
  - STOPPING is reported as running=1. If en returns to 1 in STOPPING, go back to RUN with no interruption.
- Waveform (per period, cnt=0 is the first cycle):
  - H = ceil(N/2) cycles high, then N-H cycles low.
  - pos_q is registered: pos_q=1 when cnt<H.
  - tick is registered and equals 1 in the cycle where cnt=0 in RUN/STOPPING.
  - First tick and first out_clk high occur 1 cycle after the en-sampling edge.
- Duty cycle:
  - Even N: exact 50%. N=8 is high 4, low 4, matching the legacy divider.
  - Odd N with ODD50=0: high (N+1)/2 cycles, low (N-1)/2 cycles.
  - Odd N with ODD50=1: out_clk = pos_q AND neg_q, where neg_q is pos_q re-registered on the clk falling edge. High time is N/2 clk periods.
  - Even N with ODD50=1: out_clk = pos_q (neg path bypassed).
- Divisor update:
  - div_load=1 with div_in>=2: pend_div<=div_in and div_pending<=1 on that edge.
  - div_load=1 with div_in<2: div_err pulses 1 cycle; pend_div and div_pending are unchanged.
  - At the wrap edge (cnt=cur_div-1) with div_pending=1: cur_div<=pend_div, div_pending<=0, and the new period uses the new N.
  - Only the registered pend_div is applied. A div_load in the same cycle as a wrap is therefore applied at the following wrap.
  - A second load while pending overwrites pend_div; the last value wins.
  - A load in IDLE is applied on the IDLE->RUN transition.
- Width rules: cnt is WIDTH bits; the compare uses cur_div-1, and it never overflows because N <= 2^WIDTH-1.
- out_clk must never glitch. All its combinational inputs are flops, and only the single AND gate is used when ODD50=1.

Decomposition:
- clk_div_pkg holds:
  - the state enum (IDLE, RUN, STOPPING);
  - localparam MIN_DIV=2;
  - the function half_hi(N) = (N+1)>>1.
- One sub-module, clk_div_cnt, contains the period counter with its wrap flag and the pos_q/tick registers.
- The top level contains the FSM, the divisor/pending logic and the ODD50 output stage.

Test Plan:
- Reset release with en=1 and default N=8: tick every 8 cycles; out_clk high 4 cycles, low 4 cycles; cur_div=8; running=1.
- Load div_in=5 mid-period, ODD50=0: div_pending=1 until the wrap, then out_clk is high 3, low 2 and ticks occur every 5 cycles. The old period completes untruncated.
- ODD50=1 with N=3: out_clk high for 1.5 clk periods, low for 1.5; no glitches; tick every 3 cycles.
- div_load with div_in=1, then div_in=0: two div_err pulses; cur_div and div_pending are unchanged.
- Loads of 6 then 10 within one period: only 10 is applied, at the next wrap. A load presented on a wrap cycle takes effect one period later.
- Drop en at cnt=2 with N=8: the period finishes, then out_clk=0 and running=0. Re-assert en in STOPPING: no gap in the tick stream. Assert reset mid-high: out_clk is 0 immediately (async).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The state enum, the smallest legal divisor and the high-phase length function live here.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

    // Number of high cycles in one period: ceil(n/2).
    function automatic logic [31:0] half_hi(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for the programmable divider.
// Produces the wrap flag and the registered high-phase (pos_q) and period-start (tick) outputs.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic [WIDTH-1:0] cur_div,
    output logic             wrap,
    output logic             pos_q,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] last_cnt;
    logic             pos_next;
    logic             tick_next;

    // cur_div is at least 2, so subtracting one cannot wrap below zero.
    assign last_cnt = cur_div - WIDTH'(1);
    assign wrap     = active && (cnt_reg == last_cnt);

    always_comb begin
        cnt_next  = cnt_reg;
        pos_next  = 1'b0;
        tick_next = 1'b0;
        if (!active || wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + WIDTH'(1);
        end
        if (active) begin
            pos_next  = (32'(cnt_reg) < half_hi(32'(cur_div)));
            tick_next = (cnt_reg == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            pos_q   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            pos_q   <= pos_next;
            tick    <= tick_next;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with boundary-aligned divisor updates
// and start/stop, plus an optional half-cycle stage for 50% duty on odd divisors.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8,
    parameter bit ODD50       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             div_pending,
    output logic             div_err,
    output logic [WIDTH-1:0] cur_div,
    output logic             running,
    output logic             tick,
    output logic             out_clk
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] cur_div_reg;
    logic [WIDTH-1:0] pend_div_reg;
    logic             pending_reg;
    logic             err_reg;
    logic             active;
    logic             wrap;
    logic             pos_q;
    logic             start;
    logic             apply;
    logic             load_ok;
    logic             load_bad;

    assign active = (state_reg != IDLE);
    assign start  = (state_reg == IDLE) && en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (en) state_next = RUN;
            end
            RUN, STOPPING: begin
                // A stop request only retires the block once the current period ends.
                if (wrap) state_next = en ? RUN : IDLE;
                else      state_next = en ? RUN : STOPPING;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    assign load_ok  = div_load && (div_in >= WIDTH'(MIN_DIV));
    assign load_bad = div_load && !load_ok;
    assign apply    = pending_reg && (wrap || start);

    // A fresh load wins over clearing pending, so a load on a wrap cycle waits one period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_div_reg  <= WIDTH'(DEFAULT_DIV);
            pend_div_reg <= '0;
            pending_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= load_bad;
            if (apply) cur_div_reg <= pend_div_reg;
            if (load_ok) begin
                pend_div_reg <= div_in;
                pending_reg  <= 1'b1;
            end else if (apply) begin
                pending_reg <= 1'b0;
            end
        end
    end

    clk_div_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .active  (active),
        .cur_div (cur_div_reg),
        .wrap    (wrap),
        .pos_q   (pos_q),
        .tick    (tick)
    );

    generate
        if (ODD50) begin : g_odd50
            logic neg_q;
            // For even divisors neg_q parks high, so the AND gate passes pos_q untouched.
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) neg_q <= 1'b0;
                else        neg_q <= pos_q | ~cur_div_reg[0];
            end
            assign out_clk = pos_q & neg_q;
        end else begin : g_plain
            assign out_clk = pos_q;
        end
    endgenerate

    assign div_pending = pending_reg;
    assign div_err     = err_reg;
    assign cur_div     = cur_div_reg;
    assign running     = active;

endmodule
